// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared encodings and constants for the multiply/divide unit
package mdu_pkg;

  localparam int MDU_WIDTH = 32;
  localparam int MDU_ITER  = MDU_WIDTH;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } mdu_state_e;

endpackage

// File: rtl/mdu_datapath.sv
// rtl/mdu_datapath.sv - one-bit-per-cycle shift-add / restoring shift-subtract engine
module mdu_datapath
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_ITER
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic               is_div,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  output logic [2*WIDTH-1:0] acc,
  output logic               last
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0]   opnd;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     msum;
  logic [WIDTH:0]     dtrial;
  logic [WIDTH:0]     ddiff;
  logic [2*WIDTH-1:0] acc_next;

  // acc holds {partial_high, multiplier} for multiply and {remainder, dividend/quotient} for divide
  always_comb begin
    addend   = acc[0] ? opnd : '0;
    msum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    dtrial   = acc[2*WIDTH-1:WIDTH-1];
    ddiff    = dtrial - {1'b0, opnd};
    acc_next = {msum, acc[WIDTH-1:1]};
    if (is_div) begin
      if (ddiff[WIDTH]) acc_next = {acc[2*WIDTH-2:0], 1'b0};
      else              acc_next = {ddiff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc  <= '0;
      opnd <= '0;
      cnt  <= '0;
    end else if (load) begin
      acc  <= {{WIDTH{1'b0}}, x};
      opnd <= y;
      cnt  <= '0;
    end else if (step) begin
      acc  <= acc_next;
      cnt  <= cnt + CW'(1);
    end
  end

  assign last = (cnt == CW'(WIDTH - 1));

endmodule

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  mdu_state_e state, state_next;

  logic               load, step, last;
  logic               is_signed, sa, sb;
  logic [WIDTH-1:0]   xmag, ymag;
  logic [2*WIDTH-1:0] acc;
  logic               is_div_q, sign_q, sign_r_q, dz_q;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;

  assign is_signed = (op == MDU_MULT) || (op == MDU_DIV);
  assign sa        = is_signed & a[WIDTH-1];
  assign sb        = is_signed & b[WIDTH-1];
  assign xmag      = sa ? -a : a;
  assign ymag      = sb ? -b : b;

  mdu_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .step   (step),
    .is_div (is_div_q),
    .x      (xmag),
    .y      (ymag),
    .acc    (acc),
    .last   (last)
  );

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    case (state)
      IDLE: if (start) begin
        load       = 1'b1;
        state_next = CALC;
      end
      CALC: begin
        step = 1'b1;
        if (last) state_next = FIX;
      end
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Divide by zero yields an all-ones quotient regardless of sign; the remainder path already returns a
  always_comb begin
    prod = sign_q ? -acc : acc;
    quo  = sign_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    if (dz_q) quo = '1;
    rem  = sign_r_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      is_div_q <= 1'b0;
      sign_q   <= 1'b0;
      sign_r_q <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state <= state_next;
      done  <= (state == FIX);
      if (load) begin
        is_div_q <= op[1];
        sign_q   <= sa ^ sb;
        sign_r_q <= sa;
        dz_q     <= (b == '0);
      end
      if (state == FIX) begin
        if (is_div_q) begin
          hi <= rem;
          lo <= quo;
        end else begin
          hi <= prod[2*WIDTH-1:WIDTH];
          lo <= prod[WIDTH-1:0];
        end
      end else if (state == IDLE && !start) begin
        if (hi_we) hi <= wdata;
        if (lo_we) lo <= wdata;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - directed self-checking bench for mul_div_unit
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        hi_we, lo_we;
  logic [31:0] wdata;
  logic        busy, done;
  logic [31:0] hi, lo;

  int passed = 0;
  int total  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  mul_div_unit dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (busy === 1'b1 && cycles < 100) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic run_check(input string tag, input logic [1:0] o, input logic [31:0] x,
                           input logic [31:0] y, input logic [31:0] ehi, input logic [31:0] elo);
    int n;
    start_op(o, x, y);
    wait_done(n);
    check({tag, "_busy_cycles"}, 32'(n), 32'd33);
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_hi"}, hi, ehi);
    check({tag, "_lo"}, lo, elo);
    @(negedge clk);
    check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int n;
    int seen;
    reset = 1'b1;
    start = 1'b0;
    op    = 2'b00;
    a     = '0;
    b     = '0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    wdata = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);

    run_check("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_check("mult_neg", 2'b00, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1);
    run_check("div_neg", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_check("divu_small", 2'b11, 32'd7, 32'd2, 32'd1, 32'd3);
    run_check("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000);
    run_check("divu_zero", 2'b11, 32'h00001234, 32'd0, 32'h00001234, 32'hFFFFFFFF);
    run_check("div_zero_neg", 2'b10, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF);

    // start and MTHI during CALC must be ignored, and operand changes must not leak in
    start_op(2'b01, 32'd3, 32'd4);
    repeat (5) @(negedge clk);
    start = 1'b1;
    op    = 2'b11;
    a     = 32'd100;
    b     = 32'd7;
    hi_we = 1'b1;
    wdata = 32'h0000DEAD;
    @(negedge clk);
    start = 1'b0;
    hi_we = 1'b0;
    wait_done(n);
    check("busy_ignore_done", {31'd0, done}, 32'd1);
    check("busy_ignore_hi", hi, 32'd0);
    check("busy_ignore_lo", lo, 32'd12);
    @(negedge clk);
    check("busy_ignore_no_restart", {31'd0, busy}, 32'd0);

    hi_we = 1'b1;
    lo_we = 1'b1;
    wdata = 32'hA5A5A5A5;
    @(negedge clk);
    hi_we = 1'b0;
    lo_we = 1'b0;
    check("mthi", hi, 32'hA5A5A5A5);
    check("mtlo", lo, 32'hA5A5A5A5);

    // start wins over a same-cycle MTLO
    start = 1'b1;
    op    = 2'b11;
    a     = 32'd7;
    b     = 32'd2;
    lo_we = 1'b1;
    wdata = 32'h0000DEAD;
    @(negedge clk);
    start = 1'b0;
    lo_we = 1'b0;
    check("start_prec_lo_hold", lo, 32'hA5A5A5A5);
    wait_done(n);
    check("start_prec_done", {31'd0, done}, 32'd1);
    check("start_prec_hi", hi, 32'd1);
    check("start_prec_lo", lo, 32'd3);

    // reset mid-multiply discards everything
    start_op(2'b00, 32'hFFFFFFFD, 32'd5);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset_busy", {31'd0, busy}, 32'd0);
    check("midreset_done", {31'd0, done}, 32'd0);
    check("midreset_hi", hi, 32'd0);
    check("midreset_lo", lo, 32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    check("midreset_quiet", 32'(seen), 32'd0);

    run_check("after_reset", 2'b01, 32'h00010000, 32'h00010000, 32'd1, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
